// File: rtl/ysyx_24090018_pkg.sv
// Shared definitions for the ysyx_24090018 core: fetch FSM states and fetch-stage constants.
package ysyx_24090018_pkg;

    typedef enum logic [2:0] {
        ST_REQ   = 3'd0,
        ST_WAIT  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_24090018_ifetch.sv
// Instruction fetch stage: owns the fetch PC, requests instruction memory,
// holds the fetched instruction for decode and follows redirects from execute.
module ysyx_24090018_ifetch
    import ysyx_24090018_pkg::*;
#(
    parameter int                 PC_ADDR    = 32,
    parameter int                 DATA_WIDTH = 32,
    parameter logic [PC_ADDR-1:0] RESET_PC   = PC_ADDR'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid_o,
    input  logic                  imem_req_ready_i,
    output logic [PC_ADDR-1:0]    imem_req_addr_o,
    input  logic                  imem_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data_i,
    input  logic                  imem_rsp_err_i,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [PC_ADDR-1:0]    pc_o,
    input  logic                  redirect_i,
    input  logic [PC_ADDR-1:0]    redirect_pc_i,
    output logic                  fault_o
);

    fetch_state_e          state_reg, state_next;
    logic [PC_ADDR-1:0]    fetch_pc_reg, fetch_pc_next;
    logic [DATA_WIDTH-1:0] inst_reg, inst_next;
    logic [PC_ADDR-1:0]    pc_reg, pc_next;
    logic                  fault_reg, fault_next;
    logic                  inst_valid_reg;
    logic                  redirect_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_REQ;
            fetch_pc_reg   <= RESET_PC;
            inst_reg       <= DATA_WIDTH'(NOP_INST);
            pc_reg         <= RESET_PC;
            fault_reg      <= 1'b0;
            inst_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            fetch_pc_reg   <= fetch_pc_next;
            inst_reg       <= inst_next;
            pc_reg         <= pc_next;
            fault_reg      <= fault_next;
            inst_valid_reg <= (state_next == ST_HOLD);
        end
    end

    // A misaligned redirect beats every other event, but HALT ignores redirects.
    assign redirect_bad = redirect_i && (redirect_pc_i[1:0] != 2'b00) && (state_reg != ST_HALT);

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        inst_next     = inst_reg;
        pc_next       = pc_reg;
        fault_next    = fault_reg;

        if (redirect_bad) begin
            fault_next = 1'b1;
            state_next = ST_HALT;
        end else begin
            case (state_reg)
                ST_REQ: begin
                    if (redirect_i) begin
                        fetch_pc_next = redirect_pc_i;
                    end else if (imem_req_ready_i) begin
                        state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (redirect_i) begin
                        fetch_pc_next = redirect_pc_i;
                        state_next    = imem_rsp_valid_i ? ST_REQ : ST_DRAIN;
                    end else if (imem_rsp_valid_i) begin
                        if (imem_rsp_err_i) begin
                            fault_next = 1'b1;
                            state_next = ST_HALT;
                        end else begin
                            inst_next  = imem_rsp_data_i;
                            pc_next    = fetch_pc_reg;
                            state_next = ST_HOLD;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (redirect_i) begin
                        fetch_pc_next = redirect_pc_i;
                    end
                    if (imem_rsp_valid_i) begin
                        state_next = ST_REQ;
                    end
                end
                ST_HOLD: begin
                    if (redirect_i) begin
                        fetch_pc_next = redirect_pc_i;
                        state_next    = ST_REQ;
                    end else if (inst_ready_i) begin
                        fetch_pc_next = fetch_pc_reg + PC_ADDR'(4);
                        state_next    = ST_REQ;
                    end
                end
                ST_HALT: begin
                    state_next = ST_HALT;
                end
                default: begin
                    state_next = ST_REQ;
                end
            endcase
        end
    end

    assign imem_req_valid_o = (state_reg == ST_REQ) && !redirect_i;
    assign imem_req_addr_o  = fetch_pc_reg;
    assign inst_valid_o     = inst_valid_reg;
    assign inst_o           = inst_reg;
    assign pc_o             = pc_reg;
    assign fault_o          = fault_reg;

endmodule

// File: tb/tb_ysyx_24090018_ifetch.sv
// Directed self-checking bench for the ysyx_24090018 instruction fetch stage.
module tb_ysyx_24090018_ifetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        imem_rsp_err_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        fault_o;

    int checks   = 0;
    int failures = 0;

    ysyx_24090018_ifetch dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .imem_rsp_err_i   (imem_rsp_err_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .pc_o             (pc_o),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .fault_o          (fault_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'h0;
        imem_rsp_err_i   = 1'b0;
        inst_ready_i     = 1'b0;
        redirect_i       = 1'b0;
        redirect_pc_i    = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst = 1'b1;
        #2;
        checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL reset_inst_valid got=%b exp=0", inst_valid_o); end
        checks++; if (inst_o !== 32'h0000_0013) begin failures++; $display("FAIL reset_inst got=%h exp=00000013", inst_o); end
        checks++; if (pc_o !== 32'h8000_0000) begin failures++; $display("FAIL reset_pc got=%h exp=80000000", pc_o); end
        checks++; if (fault_o !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fault_o); end
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (imem_req_valid_o !== 1'b1) begin failures++; $display("FAIL reset_req_valid got=%b exp=1", imem_req_valid_o); end
        checks++; if (imem_req_addr_o !== 32'h8000_0000) begin failures++; $display("FAIL reset_req_addr got=%h exp=80000000", imem_req_addr_o); end
        $display("txn reset released req_addr=%h", imem_req_addr_o);
    endtask

    // Accept a request, return a response one cycle later, land in HOLD.
    task automatic fetch_one(input logic [31:0] data);
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        checks++; if (imem_req_valid_o !== 1'b0) begin failures++; $display("FAIL wait_req_valid got=%b exp=0", imem_req_valid_o); end
        checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL wait_inst_valid got=%b exp=0", inst_valid_o); end
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = data;
        tick();
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'h0;
    endtask

    task automatic test_first_fetch();
        fetch_one(32'h0010_0093);
        checks++; if (inst_valid_o !== 1'b1) begin failures++; $display("FAIL first_inst_valid got=%b exp=1", inst_valid_o); end
        checks++; if (inst_o !== 32'h0010_0093) begin failures++; $display("FAIL first_inst got=%h exp=00100093", inst_o); end
        checks++; if (pc_o !== 32'h8000_0000) begin failures++; $display("FAIL first_pc got=%h exp=80000000", pc_o); end
        $display("txn fetch pc=%h inst=%h", pc_o, inst_o);
    endtask

    task automatic test_hold_stall();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (inst_o !== 32'h0010_0093 || pc_o !== 32'h8000_0000) begin failures++; $display("FAIL hold_stable cyc=%0d got=%h/%h exp=00100093/80000000", i, inst_o, pc_o); end
            checks++; if (imem_req_valid_o !== 1'b0 || inst_valid_o !== 1'b1) begin failures++; $display("FAIL hold_valids cyc=%0d got req=%b inst=%b exp req=0 inst=1", i, imem_req_valid_o, inst_valid_o); end
        end
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL consume_inst_valid got=%b exp=0", inst_valid_o); end
        checks++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0004) begin failures++; $display("FAIL next_req got=%b/%h exp=1/80000004", imem_req_valid_o, imem_req_addr_o); end
        $display("txn consume next_req=%h", imem_req_addr_o);
    endtask

    task automatic test_redirect_wait();
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h8000_0100;
        tick();
        redirect_i    = 1'b0;
        tick();
        checks++; if (imem_req_valid_o !== 1'b0) begin failures++; $display("FAIL drain_req_valid got=%b exp=0", imem_req_valid_o); end
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid_i = 1'b0;
        checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL drain_inst_valid got=%b exp=0", inst_valid_o); end
        checks++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0100) begin failures++; $display("FAIL redirect_req got=%b/%h exp=1/80000100", imem_req_valid_o, imem_req_addr_o); end
        tick();
        checks++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h0010_0093) begin failures++; $display("FAIL drain_dropped got=%b/%h exp=0/00100093", inst_valid_o, inst_o); end
        $display("txn redirect in WAIT next_req=%h", imem_req_addr_o);
    endtask

    task automatic test_wrap();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        #1;
        checks++; if (imem_req_valid_o !== 1'b0) begin failures++; $display("FAIL redirect_withdraw got=%b exp=0", imem_req_valid_o); end
        tick();
        redirect_i = 1'b0;
        #1;
        checks++; if (imem_req_addr_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_req got=%h exp=fffffffc", imem_req_addr_o); end
        fetch_one(32'h0020_0113);
        checks++; if (inst_o !== 32'h0020_0113 || pc_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_hold got=%h/%h exp=00200113/fffffffc", inst_o, pc_o); end
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        checks++; if (imem_req_addr_o !== 32'h0000_0000) begin failures++; $display("FAIL wrap_next got=%h exp=00000000", imem_req_addr_o); end
        $display("txn wrap pc=fffffffc next_req=%h", imem_req_addr_o);
    endtask

    task automatic test_rst_mid_wait();
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h0000_0013 || fault_o !== 1'b0) begin failures++; $display("FAIL async_rst got=%b/%h/%b exp=0/00000013/0", inst_valid_o, inst_o, fault_o); end
        checks++; if (pc_o !== 32'h8000_0000) begin failures++; $display("FAIL async_rst_pc got=%h exp=80000000", pc_o); end
        tick();
        rst = 1'b0;
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'hBAD0_0BAD;
        tick();
        imem_rsp_valid_i = 1'b0;
        checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL stale_rsp got=%b exp=0", inst_valid_o); end
        checks++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0000) begin failures++; $display("FAIL post_rst_req got=%b/%h exp=1/80000000", imem_req_valid_o, imem_req_addr_o); end
        fetch_one(32'h0030_0193);
        checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0030_0193 || pc_o !== 32'h8000_0000) begin failures++; $display("FAIL post_rst_fetch got=%b/%h/%h exp=1/00300193/80000000", inst_valid_o, inst_o, pc_o); end
        $display("txn fetch after reset pc=%h inst=%h", pc_o, inst_o);
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
    endtask

    task automatic test_misaligned_redirect();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h8000_0102;
        tick();
        redirect_i = 1'b0;
        checks++; if (fault_o !== 1'b1) begin failures++; $display("FAIL misalign_fault got=%b exp=1", fault_o); end
        imem_req_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            redirect_i    = (i == 1);
            redirect_pc_i = 32'h8000_0200;
            #1;
            checks++; if (imem_req_valid_o !== 1'b0 || inst_valid_o !== 1'b0 || fault_o !== 1'b1) begin failures++; $display("FAIL halt_quiet cyc=%0d got=%b/%b/%b exp=0/0/1", i, imem_req_valid_o, inst_valid_o, fault_o); end
            tick();
        end
        idle_inputs();
        $display("txn misaligned redirect fault=%b", fault_o);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (fault_o !== 1'b0 || imem_req_valid_o !== 1'b1) begin failures++; $display("FAIL halt_recover got=%b/%b exp=0/1", fault_o, imem_req_valid_o); end
    endtask

    task automatic test_rsp_err();
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b1;
        imem_rsp_err_i   = 1'b1;
        imem_rsp_data_i  = 32'h0040_0213;
        tick();
        idle_inputs();
        checks++; if (fault_o !== 1'b1 || inst_valid_o !== 1'b0) begin failures++; $display("FAIL err_fault got=%b/%b exp=1/0", fault_o, inst_valid_o); end
        tick();
        checks++; if (imem_req_valid_o !== 1'b0 || inst_o !== 32'h0000_0013) begin failures++; $display("FAIL err_halt got=%b/%h exp=0/00000013", imem_req_valid_o, inst_o); end
        $display("txn response error fault=%b", fault_o);
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_hold_stall();
        test_redirect_wait();
        test_wrap();
        test_rst_mid_wait();
        test_misaligned_redirect();
        test_rsp_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
